// File: rtl/fir_sym_mac_filter_if.sv
// Sample stream, result and coefficient-write signals of the symmetric FIR.
// The filter is the slave; whatever feeds samples and coefficients is the master.
interface fir_sym_mac_filter_if #(
    parameter int DATA_W = 10,
    parameter int COEF_W = 12,
    parameter int AW     = 4
);
    logic                     in_valid;
    logic [DATA_W-1:0]        in_data;
    logic                     in_ready;
    logic                     out_valid;
    logic [DATA_W-1:0]        out_data;
    logic                     flush;
    logic                     coef_we;
    logic [AW-1:0]            coef_addr;
    logic signed [COEF_W-1:0] coef_data;
    logic                     coef_err;

    modport master (
        output in_valid, in_data, flush, coef_we, coef_addr, coef_data,
        input  in_ready, out_valid, out_data, coef_err
    );

    modport slave (
        input  in_valid, in_data, flush, coef_we, coef_addr, coef_data,
        output in_ready, out_valid, out_data, coef_err
    );
endinterface

// File: rtl/fir_sym_mac_filter.sv
// Symmetric FIR low-pass for the PPG stream: one pre-add/multiply/accumulate
// per cycle over the M unique coefficients, then round, saturate and emit.
//
// state | meaning
// IDLE  | waiting for a sample; coefficient writes accepted here only
// MAC   | accumulating term k = 0..M-1 (pre-added tap pair times c[k])
// OUT   | rounding/saturating the accumulator into out_data
module fir_sym_mac_filter #(
    parameter int DATA_W = 10,
    parameter int NTAPS  = 31,
    parameter int COEF_W = 12,
    parameter int FRAC   = 10
) (
    input  logic                clk,
    input  logic                reset,
    fir_sym_mac_filter_if.slave bus
);
    localparam int M      = (NTAPS + 1) / 2;
    localparam int AW     = $clog2(M);
    localparam int IW     = $clog2(NTAPS);
    localparam int PRE_W  = DATA_W + 1;
    localparam int PROD_W = COEF_W + PRE_W + 1;
    localparam int ACC_W  = DATA_W + 1 + COEF_W + $clog2(M) + 1;
    // Unity gain at the centre tap when it is representable, else the largest positive value.
    localparam int CENTRE_RST = (FRAC < COEF_W - 1) ? (1 << FRAC) : ((1 << (COEF_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(1 << (FRAC - 1));
    localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'((1 << DATA_W) - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [DATA_W-1:0]        v_q [NTAPS];
    logic signed [COEF_W-1:0] c_q [M];
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [AW-1:0]            k_q;
    logic [DATA_W-1:0]        out_data_q, out_data_d;
    logic                     out_valid_q;
    logic                     coef_err_q;

    logic                     accept;
    logic                     last_k;
    logic                     coef_ok;
    logic [DATA_W-1:0]        tap_lo, tap_hi;
    logic signed [PRE_W:0]    pre_s;
    logic signed [PROD_W-1:0] c_ext, p_ext, prod;
    logic signed [ACC_W-1:0]  rnd, shifted;

    // Ready is forced low while reset is held so nothing is offered a handshake mid-reset.
    assign bus.in_ready  = (state_q == IDLE) && !reset;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.coef_err  = coef_err_q;

    assign accept  = bus.in_valid && (state_q == IDLE) && !bus.flush;
    assign last_k  = (k_q == AW'(M - 1));
    assign coef_ok = (state_q == IDLE) && (32'(bus.coef_addr) < 32'(M));

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state: one sample walks IDLE -> MAC (M cycles) -> OUT; flush always returns to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = MAC;
            MAC:     if (last_k) state_d = OUT;
            OUT:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.flush) state_d = IDLE;
    end

    // Datapath: pre-add the mirrored tap pair (centre tap alone), multiply, accumulate, round, clamp.
    always_comb begin
        tap_lo  = v_q[IW'(k_q)];
        tap_hi  = last_k ? '0 : v_q[IW'(NTAPS - 1) - IW'(k_q)];
        pre_s   = {2'b00, tap_lo} + {2'b00, tap_hi};
        c_ext   = PROD_W'(c_q[k_q]);
        p_ext   = PROD_W'(pre_s);
        prod    = c_ext * p_ext;
        acc_d   = acc_q + ACC_W'(prod);
        rnd     = acc_q + RND_HALF;
        shifted = rnd >>> FRAC;
        if (shifted[ACC_W-1])       out_data_d = '0;
        else if (shifted > SAT_MAX) out_data_d = '1;
        else                        out_data_d = shifted[DATA_W-1:0];
    end

    // Delay line, accumulator and term index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NTAPS; i++) v_q[i] <= '0;
            acc_q <= '0;
            k_q   <= '0;
        end else if (bus.flush) begin
            for (int i = 0; i < NTAPS; i++) v_q[i] <= '0;
            acc_q <= '0;
            k_q   <= '0;
        end else if (accept) begin
            v_q[0] <= bus.in_data;
            for (int i = 1; i < NTAPS; i++) v_q[i] <= v_q[i-1];
            acc_q <= '0;
            k_q   <= '0;
        end else if (state_q == MAC) begin
            acc_q <= acc_d;
            k_q   <= k_q + AW'(1);
        end
    end

    // Result register; a flushed OUT cycle produces no pulse and leaves out_data alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= (state_q == OUT) && !bus.flush;
            if ((state_q == OUT) && !bus.flush) out_data_q <= out_data_d;
        end
    end

    // Coefficient bank; writes outside IDLE or out of range are dropped and latch the error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < M; i++) c_q[i] <= '0;
            c_q[M-1]   <= COEF_W'(CENTRE_RST);
            coef_err_q <= 1'b0;
        end else if (bus.coef_we) begin
            if (coef_ok) c_q[bus.coef_addr] <= bus.coef_data;
            else         coef_err_q         <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fir_sym_mac_filter.sv
// Bench for the symmetric FIR: a convolution-level reference model is checked
// against the DUT every cycle, plus literal expectations for known scenarios.
module tb_fir_sym_mac_filter;
    localparam int DATA_W = 10;
    localparam int NTAPS  = 31;
    localparam int COEF_W = 12;
    localparam int FRAC   = 10;
    localparam int M      = (NTAPS + 1) / 2;
    localparam int AW     = $clog2(M);

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fir_sym_mac_filter_if #(.DATA_W(DATA_W), .COEF_W(COEF_W), .AW(AW)) bus();

    fir_sym_mac_filter #(.DATA_W(DATA_W), .NTAPS(NTAPS), .COEF_W(COEF_W), .FRAC(FRAC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: delay line and full-length symmetric coefficient view.
    int m_v [NTAPS];
    int m_c [M];
    int m_busy;
    int m_pend;
    int m_data;
    bit m_valid;
    bit m_err;

    int res_q [$];
    int vcyc_q [$];

    function automatic int model_result();
        longint acc = 0;
        longint r;
        for (int i = 0; i < NTAPS; i++) begin
            int k = (i < M) ? i : (NTAPS - 1 - i);
            acc += longint'(m_c[k]) * longint'(m_v[i]);
        end
        r = (acc + (longint'(1) << (FRAC - 1))) >>> FRAC;
        if (r < 0) r = 0;
        if (r > (1 << DATA_W) - 1) r = (1 << DATA_W) - 1;
        return int'(r);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NTAPS; i++) m_v[i] = 0;
        for (int i = 0; i < M; i++) m_c[i] = 0;
        m_c[M-1] = (FRAC < COEF_W - 1) ? (1 << FRAC) : ((1 << (COEF_W - 1)) - 1);
        m_busy = 0; m_pend = 0; m_data = 0; m_valid = 0; m_err = 0;
    endtask

    // Effect of the coming rising edge, given the inputs currently driven.
    task automatic model_step();
        bit idle = (m_busy == 0);
        m_valid = 0;
        if (bus.coef_we) begin
            if (idle && int'(bus.coef_addr) < M) m_c[bus.coef_addr] = int'(bus.coef_data);
            else m_err = 1;
        end
        if (bus.flush) begin
            for (int i = 0; i < NTAPS; i++) m_v[i] = 0;
            m_busy = 0;
        end else if (!idle) begin
            m_busy--;
            if (m_busy == 0) begin
                m_valid = 1;
                m_data  = m_pend;
            end
        end else if (bus.in_valid) begin
            for (int i = NTAPS - 1; i > 0; i--) m_v[i] = m_v[i-1];
            m_v[0] = int'(bus.in_data);
            m_pend = model_result();
            m_busy = M + 1;
        end
    endtask

    // Compare process: outputs vs model every cycle, then advance the model.
    always @(negedge clk) begin
        if (reset) model_reset();
        chk("in_ready",  bus.in_ready,  (m_busy == 0) && !reset);
        chk("out_valid", bus.out_valid, m_valid);
        chk("out_data",  bus.out_data,  m_data);
        chk("coef_err",  bus.coef_err,  m_err);
        if (bus.out_valid) begin
            res_q.push_back(int'(bus.out_data));
            vcyc_q.push_back(cyc);
        end
        if (!reset) model_step();
    end

    int acc_cyc = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int d);
        bit done;
        done = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = DATA_W'(d);
        for (int n = 0; n < 40 && !done; n++) begin
            if (bus.in_ready) begin
                acc_cyc = cyc + 1;
                done = 1;
            end
            tick();
        end
        bus.in_valid = 1'b0;
        if (!done) chk("send_timeout", done, 1);
    endtask

    task automatic drain();
        int n = 0;
        while (!bus.in_ready && n < 40) begin
            tick();
            n++;
        end
        chk("drain_ready", bus.in_ready, 1);
        tick();
    endtask

    task automatic cwrite(input int a, input int d);
        bus.coef_we   = 1'b1;
        bus.coef_addr = AW'(a);
        bus.coef_data = COEF_W'(d);
        tick();
        bus.coef_we   = 1'b0;
    endtask

    task automatic flush_pulse();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
    endtask

    task automatic centre_only(input int c);
        for (int k = 0; k < M - 1; k++) cwrite(k, 0);
        cwrite(M - 1, c);
        flush_pulse();
    endtask

    task automatic impulse_check(input string name, input int amp);
        res_q.delete();
        send(amp);
        for (int i = 0; i < NTAPS - 1; i++) send(0);
        drain();
        chk({name, "_count"}, res_q.size(), NTAPS);
        for (int i = 0; i < NTAPS; i++) chk({name, "_res"}, res_q[i], (i == (NTAPS - 1) / 2) ? amp : 0);
    endtask

    initial begin
        int first_acc;
        int n_acc;
        bus.in_valid = 0; bus.in_data = '0; bus.flush = 0;
        bus.coef_we = 0; bus.coef_addr = '0; bus.coef_data = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  bus.in_ready,  0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data",  bus.out_data,  0);
        chk("rst_coef_err",  bus.coef_err,  0);
        reset = 1'b0;
        #1;
        chk("post_rst_ready", bus.in_ready, 1);
        tick();

        // Default coefficients: pure delay of 15 samples, latency 17 cycles.
        res_q.delete(); vcyc_q.delete();
        send(1023);
        first_acc = acc_cyc;
        for (int i = 0; i < NTAPS - 1; i++) send(0);
        drain();
        chk("imp_count", res_q.size(), NTAPS);
        for (int i = 0; i < NTAPS; i++) chk("imp_res", res_q[i], (i == 15) ? 1023 : 0);
        chk("imp_latency", vcyc_q[0] - first_acc, 17);

        // Moving average: c[0..15] = 32, total gain 992/1024.
        for (int k = 0; k < M; k++) cwrite(k, 32);
        res_q.delete();
        for (int i = 0; i < 40; i++) send(512);
        drain();
        chk("mavg_count", res_q.size(), 40);
        chk("mavg_full",  res_q[30], 496);
        chk("mavg_last",  res_q[39], 496);

        // Rounding and saturation with a lone centre tap.
        centre_only(1);
        res_q.delete();
        send(512); send(511);
        for (int i = 0; i < 15; i++) send(0);
        drain();
        chk("rnd_512", res_q[15], 1);
        chk("rnd_511", res_q[16], 0);

        centre_only(2047);
        res_q.delete();
        send(1023);
        for (int i = 0; i < 15; i++) send(0);
        drain();
        chk("sat_hi", res_q[15], 1023);

        centre_only(-1024);
        res_q.delete();
        send(700);
        for (int i = 0; i < 15; i++) send(0);
        drain();
        chk("sat_lo", res_q[15], 0);

        // Continuous in_valid: one accept per 18 cycles.
        centre_only(1024);
        res_q.delete();
        n_acc = 0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 90; i++) begin
            bus.in_data = DATA_W'(i);
            if (bus.in_ready) n_acc++;
            tick();
        end
        bus.in_valid = 1'b0;
        drain();
        chk("stream_accepts", n_acc, 5);
        chk("stream_outputs", res_q.size(), 5);

        // Write while busy is dropped and latches coef_err; an IDLE write is used next.
        flush_pulse();
        res_q.delete();
        send(100);
        cwrite(0, 500);
        chk("err_set", bus.coef_err, 1);
        for (int i = 0; i < NTAPS - 1; i++) send(0);
        drain();
        chk("busy_wr_centre", res_q[15], 100);
        chk("busy_wr_c0",     res_q[30], 0);
        flush_pulse();
        cwrite(M - 1, 512);
        res_q.delete();
        send(400);
        for (int i = 0; i < 15; i++) send(0);
        drain();
        chk("idle_wr_used", res_q[15], 200);
        chk("err_sticky", bus.coef_err, 1);

        // Flush at MAC step 5 aborts the sample and empties the delay line.
        cwrite(M - 1, 1024);
        res_q.delete();
        send(1023);
        repeat (4) tick();
        flush_pulse();
        chk("flush_ready", bus.in_ready, 1);
        repeat (20) tick();
        chk("flush_no_out", res_q.size(), 0);
        impulse_check("flush_imp", 1023);

        // Randomised traffic against the model.
        for (int i = 0; i < 600; i++) begin
            bus.in_valid  = ($urandom_range(0, 2) == 0);
            bus.in_data   = DATA_W'($urandom_range(0, 1023));
            bus.coef_we   = ($urandom_range(0, 15) == 0);
            bus.coef_addr = AW'($urandom_range(0, M - 1));
            bus.coef_data = COEF_W'(int'($urandom_range(0, 2100)) - 600);
            bus.flush     = ($urandom_range(0, 49) == 0);
            tick();
        end
        bus.in_valid = 0; bus.coef_we = 0; bus.flush = 0;
        drain();

        // Reset in the middle of MAC.
        send(300);
        repeat (3) tick();
        reset = 1'b1;
        #1;
        chk("mid_rst_ready",    bus.in_ready,  0);
        chk("mid_rst_valid",    bus.out_valid, 0);
        chk("mid_rst_data",     bus.out_data,  0);
        chk("mid_rst_coef_err", bus.coef_err,  0);
        tick();
        reset = 1'b0;
        #1;
        chk("mid_rst_release", bus.in_ready, 1);
        tick();
        res_q.delete();
        send(5);
        for (int i = 0; i < 15; i++) send(0);
        drain();
        chk("post_rst_identity", res_q[15], 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d, expected finish earlier", cyc);
        $fatal(1);
    end
endmodule
